// File: rtl/spi_slave.sv
// Byte-oriented SPI slave clocked directly by SCLK; mode {CPOL,CPHA} fixed by MODE.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while CS is high.
module spi_slave #(
  parameter logic [1:0] MODE = 2'b11
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       MOSI,
  input  logic       CS,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       MISO,
  output logic       done,
  output logic [7:0] rx
);

  // Sample edge is the rising edge of sclk_s in every mode; drive edge is its fall.
  localparam logic SPOL = MODE[1] ^ MODE[0];

  logic       sclk_s;
  logic [7:0] tx_q, rsh_q, rx_q;
  logic [2:0] cnt_q;
  logic       done_q;
  logic       rsh_clr, cnt_clr, done_clr, run;
  logic       tx_bit;

  assign sclk_s   = SCLK ^ SPOL;
  assign rsh_clr  = RST | CS;
  assign cnt_clr  = RST | CS | load;
  assign done_clr = RST | load;
  assign run      = !CS && !load;

  always_ff @(posedge sclk_s or posedge cnt_clr) begin
    if (cnt_clr) cnt_q <= '0;
    else         cnt_q <= cnt_q + 3'd1;
  end

  always_ff @(posedge sclk_s or posedge rsh_clr) begin
    if (rsh_clr)    rsh_q <= '0;
    else if (!load) rsh_q <= {rsh_q[6:0], MOSI};
  end

  // cnt is forced to 0 while CS or load is high, so cnt==7 already implies an active frame.
  always_ff @(posedge sclk_s or posedge RST) begin
    if (RST)                rx_q <= '0;
    else if (cnt_q == 3'd7) rx_q <= {rsh_q[6:0], MOSI};
  end

  always_ff @(posedge sclk_s or posedge done_clr) begin
    if (done_clr) done_q <= 1'b0;
    else if (run) begin
      if (cnt_q == 3'd7)      done_q <= 1'b1;
      else if (cnt_q == 3'd0) done_q <= 1'b0;
    end
  end

  // No shift while cnt==0 keeps bit 7 up for CPHA=1's leading edge and bit 0 after CPHA=0's last sample.
  always_ff @(negedge sclk_s or posedge RST or posedge load) begin
    if (RST)                 tx_q <= '0;
    else if (load)           tx_q <= data_in;
    else if (cnt_q != 3'd0)  tx_q <= {tx_q[6:0], 1'b0};
  end

  // Load is level-sensitive: MISO follows data_in[7] for as long as the strobe is held.
  assign tx_bit = (load && !RST) ? data_in[7] : tx_q[7];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = CS ? 1'bz : tx_bit;
`else
  assign MISO = CS ? 1'b0 : tx_bit;
`endif

  assign done = done_q;
  assign rx   = rx_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench: one spi_slave per mode sharing data pins, each with its own SCLK.
module tb_spi_slave;

  logic       RST, MOSI, CS, load;
  logic [7:0] data_in;
  logic [3:0] sclk;
  logic [3:0] miso;
  logic [3:0] done_w;
  logic [7:0] rx_w [4];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mrx [4];
  logic       mdone [4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave #(.MODE(2'(m))) u_dut (
      .SCLK    (sclk[m]),
      .RST     (RST),
      .MOSI    (MOSI),
      .CS      (CS),
      .load    (load),
      .data_in (data_in),
      .MISO    (miso[m]),
      .done    (done_w[m]),
      .rx      (rx_w[m])
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // MISO bit expected at the k-th sample edge after a load (k from 0).
  function automatic logic exp_miso(input logic [7:0] d, input int k);
    if (k < 8)  return d[7-k];
    if (k == 8) return d[0];
    return 1'b0;
  endfunction

  task automatic do_load(input logic [7:0] d);
    data_in = d;
    load = 1'b1;
    #5;
    load = 1'b0;
    #5;
    for (int i = 0; i < 4; i++) mdone[i] = 1'b0;
  endtask

  // Send the top nb bits of b MSB-first; MISO is sampled just before each sample edge.
  task automatic xfer_bits(input int m, input logic [7:0] b, input int nb, output logic [7:0] mb);
    logic [7:0] sh;
    logic cpha;
    sh = b;
    mb = '0;
    cpha = m[0];
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        MOSI = sh[7];
        #5;
        mb = {mb[6:0], miso[m]};
        sclk[m] = ~sclk[m];
        #5;
        sclk[m] = ~sclk[m];
        #5;
      end else begin
        sclk[m] = ~sclk[m];
        MOSI = sh[7];
        #5;
        mb = {mb[6:0], miso[m]};
        sclk[m] = ~sclk[m];
        #5;
      end
      sh = {sh[6:0], 1'b0};
    end
  endtask

  task automatic chk_cs_high_miso(input int m);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk("miso_cs_high", {7'b0, miso[m]}, {7'b0, 1'bz});
`else
    chk("miso_cs_high", {7'b0, miso[m]}, 8'h00);
`endif
  endtask

  initial begin
    logic [7:0] mb, d, b;
    int m, k, nb;
    for (int i = 0; i < 4; i++) begin
      sclk[i] = 1'(i >> 1);
      mrx[i] = '0;
      mdone[i] = 1'b0;
    end
    RST = 1'b1; CS = 1'b0; load = 1'b0; MOSI = 1'b0; data_in = 8'hFF;
    #10;
    chk("rst_rx", rx_w[3], 8'h00);
    chk("rst_done", {7'b0, done_w[3]}, 8'h00);
    chk("rst_miso", {7'b0, miso[3]}, 8'h00);
    RST = 1'b0; CS = 1'b1;
    #5;
    chk_cs_high_miso(3);

    // Reference transfer in all four modes
    for (int mm = 0; mm < 4; mm++) begin
      CS = 1'b0; #5;
      do_load(8'hB3);
      chk("first_miso", {7'b0, miso[mm]}, 8'h01);
      xfer_bits(mm, 8'hCA, 8, mb);
      chk("mode_rx", rx_w[mm], 8'hCA);
      chk("mode_done", {7'b0, done_w[mm]}, 8'h01);
      chk("mode_miso", mb, 8'hB3);
      mrx[mm] = 8'hCA; mdone[mm] = 1'b1;
      CS = 1'b1; #5;
    end

    // RST mid-byte, then a clean byte
    CS = 1'b0; #5;
    do_load(8'hF0);
    xfer_bits(3, 8'hA5, 4, mb);
    RST = 1'b1; #2;
    chk("rst_mid_rx", rx_w[3], 8'h00);
    chk("rst_mid_done", {7'b0, done_w[3]}, 8'h00);
    chk("rst_mid_miso", {7'b0, miso[3]}, 8'h00);
    for (int i = 0; i < 4; i++) begin mrx[i] = '0; mdone[i] = 1'b0; end
    #3; RST = 1'b0; #5;
    do_load(8'h5A);
    xfer_bits(3, 8'h5A, 8, mb);
    chk("post_rst_rx", rx_w[3], 8'h5A);
    chk("post_rst_miso", mb, 8'h5A);
    mrx[3] = 8'h5A; mdone[3] = 1'b1;

    // CS abort after 5 bits, then a full byte
    do_load(8'h81);
    xfer_bits(0, 8'hFF, 5, mb);
    CS = 1'b1; #5;
    chk("abort_rx", rx_w[0], mrx[0]);
    chk("abort_done", {7'b0, done_w[0]}, 8'h00);
    CS = 1'b0; #5;
    xfer_bits(0, 8'h3C, 7, mb);
    chk("abort_done7", {7'b0, done_w[0]}, 8'h00);
    xfer_bits(0, 8'h3C << 7, 1, mb);
    chk("abort_rx2", rx_w[0], 8'h3C);
    chk("abort_done8", {7'b0, done_w[0]}, 8'h01);
    mrx[0] = 8'h3C; mdone[0] = 1'b1;

    // Back-to-back bytes without CS toggling
    do_load(8'h96);
    xfer_bits(3, 8'hCA, 8, mb);
    chk("b2b_rx1", rx_w[3], 8'hCA);
    chk("b2b_done1", {7'b0, done_w[3]}, 8'h01);
    xfer_bits(3, 8'h0F, 1, mb);
    chk("b2b_done9", {7'b0, done_w[3]}, 8'h00);
    chk("b2b_miso9", mb, {7'b0, exp_miso(8'h96, 8)});
    xfer_bits(3, 8'h0F << 1, 7, mb);
    chk("b2b_rx2", rx_w[3], 8'h0F);
    chk("b2b_done2", {7'b0, done_w[3]}, 8'h01);
    mrx[3] = 8'h0F; mdone[3] = 1'b1;
    CS = 1'b1; #5;

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      m = $urandom_range(0, 3);
      d = 8'($urandom);
      CS = 1'b0; #5;
      do_load(d);
      chk("r_first_miso", {7'b0, miso[m]}, {7'b0, d[7]});
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 7);
        xfer_bits(m, 8'($urandom), k, mb);
        CS = 1'b1; #5;
        chk("r_abort_rx", rx_w[m], mrx[m]);
        chk("r_abort_done", {7'b0, done_w[m]}, {7'b0, mdone[m]});
        CS = 1'b0; #5;
        do_load(d);
      end
      nb = $urandom_range(1, 2);
      for (int j = 0; j < nb; j++) begin
        logic [7:0] em;
        b = 8'($urandom);
        xfer_bits(m, b, 8, mb);
        for (int q = 0; q < 8; q++) em[7-q] = exp_miso(d, j*8 + q);
        mrx[m] = b; mdone[m] = 1'b1;
        chk("r_rx", rx_w[m], mrx[m]);
        chk("r_done", {7'b0, done_w[m]}, {7'b0, mdone[m]});
        chk("r_miso", mb, em);
      end
      CS = 1'b1; #5;
      chk_cs_high_miso(m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
